// File: rtl/ex_stage.sv
// ex_stage: MIPS-subset execute stage, ALU decode/compute plus EX/MA pipeline latch
// Ports: CLK/RSTn (sync active-low reset); a_i/b_i rs/rt operands; op_i, rt_i, rd_i,
// shamt_i, funct_i instruction fields (imm16 = {rd_i, shamt_i, funct_i});
// alu_ctrl_o/c_o/z_o combinational ALU outputs; ma_c_o/ma_addr_o/ma_we_o EX/MA latch.
module ex_stage #(
  parameter int WORD_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [WORD_WIDTH-1:0]    a_i,
  input  logic [WORD_WIDTH-1:0]    b_i,
  input  logic [5:0]               op_i,
  input  logic [4:0]               rt_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               shamt_i,
  input  logic [5:0]               funct_i,
  output logic [ALUCTRL_WIDTH-1:0] alu_ctrl_o,
  output logic [WORD_WIDTH-1:0]    c_o,
  output logic                     z_o,
  output logic [WORD_WIDTH-1:0]    ma_c_o,
  output logic [4:0]               ma_addr_o,
  output logic                     ma_we_o
);
  localparam logic [ALUCTRL_WIDTH-1:0] ADD = 'h0, SUB = 'h1, AND = 'h2, OR = 'h3,
    XOR = 'h4, NOR = 'h5, SLT = 'h6, SLTU = 'h7, SLL = 'h8, SRL = 'h9, SRA = 'hA,
    LUI = 'hB, NOP = 'hF;
  logic                     r_type, var_sh, sext;
  logic [ALUCTRL_WIDTH-1:0] ctrl;
  logic [15:0]              imm16;
  logic [WORD_WIDTH-1:0]    opb, c;
  logic [4:0]               sh, dest;
  logic                     we;
  logic [WORD_WIDTH-1:0]    ma_c_d, ma_c_q;
  logic [4:0]               ma_addr_d, ma_addr_q;
  logic                     ma_we_d, ma_we_q;
  assign r_type = op_i == 6'h00;
  assign imm16  = {rd_i, shamt_i, funct_i};
  always_comb begin
    ctrl   = NOP;
    var_sh = 1'b0;
    if (r_type)
      case (funct_i)
        6'h20, 6'h21: ctrl = ADD;
        6'h22, 6'h23: ctrl = SUB;
        6'h24: ctrl = AND;
        6'h25: ctrl = OR;
        6'h26: ctrl = XOR;
        6'h27: ctrl = NOR;
        6'h2A: ctrl = SLT;
        6'h2B: ctrl = SLTU;
        6'h00: ctrl = SLL;
        6'h02: ctrl = SRL;
        6'h03: ctrl = SRA;
        6'h04: begin ctrl = SLL; var_sh = 1'b1; end
        6'h06: begin ctrl = SRL; var_sh = 1'b1; end
        6'h07: begin ctrl = SRA; var_sh = 1'b1; end
        default: ctrl = NOP;
      endcase
    else
      case (op_i)
        6'h08, 6'h09: ctrl = ADD;
        6'h0A: ctrl = SLT;
        6'h0B: ctrl = SLTU;
        6'h0C: ctrl = AND;
        6'h0D: ctrl = OR;
        6'h0E: ctrl = XOR;
        6'h0F: ctrl = LUI;
        default: ctrl = NOP;
      endcase
  end
  // Arithmetic/compare immediates sign-extend; logical immediates zero-extend.
  assign sext = op_i inside {6'h08, 6'h09, 6'h0A, 6'h0B};
  assign opb  = r_type ? b_i
              : sext ? {{(WORD_WIDTH-16){imm16[15]}}, imm16}
              : {{(WORD_WIDTH-16){1'b0}}, imm16};
  assign sh   = var_sh ? a_i[4:0] : shamt_i;
  always_comb begin
    c = '0;
    case (ctrl)
      ADD:  c = a_i + opb;
      SUB:  c = a_i - opb;
      AND:  c = a_i & opb;
      OR:   c = a_i | opb;
      XOR:  c = a_i ^ opb;
      NOR:  c = ~(a_i | opb);
      SLT:  c = {{(WORD_WIDTH-1){1'b0}}, $signed(a_i) < $signed(opb)};
      SLTU: c = {{(WORD_WIDTH-1){1'b0}}, a_i < opb};
      SLL:  c = b_i << sh;
      SRL:  c = b_i >> sh;
      SRA:  c = $unsigned($signed(b_i) >>> sh);
      LUI:  c = {imm16, {(WORD_WIDTH-16){1'b0}}};
      default: c = '0;
    endcase
  end
  assign dest       = r_type ? rd_i : rt_i;
  assign we         = (ctrl != NOP) && (dest != 5'd0);
  assign alu_ctrl_o = ctrl;
  assign c_o        = c;
  assign z_o        = c == '0;
  assign ma_c_d     = c;
  assign ma_addr_d  = dest;
  assign ma_we_d    = we;
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ma_c_q    <= '0;
      ma_addr_q <= '0;
      ma_we_q   <= 1'b0;
    end else begin
      ma_c_q    <= ma_c_d;
      ma_addr_q <= ma_addr_d;
      ma_we_q   <= ma_we_d;
    end
  end
  assign ma_c_o    = ma_c_q;
  assign ma_addr_o = ma_addr_q;
  assign ma_we_o   = ma_we_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
  logic        CLK = 1'b0, RSTn = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [5:0]  op_i = '0, funct_i = '0;
  logic [4:0]  rt_i = '0, rd_i = '0, shamt_i = '0;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] c_o, ma_c_o;
  logic        z_o, ma_we_o;
  logic [4:0]  ma_addr_o;
  int n_cmp = 0, n_err = 0;

  ex_stage dut (
    .CLK(CLK), .RSTn(RSTn), .a_i(a_i), .b_i(b_i), .op_i(op_i), .rt_i(rt_i),
    .rd_i(rd_i), .shamt_i(shamt_i), .funct_i(funct_i), .alu_ctrl_o(alu_ctrl_o),
    .c_o(c_o), .z_o(z_o), .ma_c_o(ma_c_o), .ma_addr_o(ma_addr_o), .ma_we_o(ma_we_o)
  );

  always #5 CLK = ~CLK;

  task automatic rtype(input logic [31:0] a, b, input logic [4:0] rd, sa, input logic [5:0] fn);
    @(negedge CLK);
    a_i = a; b_i = b; op_i = 6'h00; rt_i = 5'd9; rd_i = rd; shamt_i = sa; funct_i = fn;
    #1;
  endtask

  task automatic itype(input logic [5:0] op, input logic [31:0] a, input logic [4:0] rt,
                       input logic [15:0] imm);
    @(negedge CLK);
    a_i = a; b_i = 32'hA5A5A5A5; op_i = op; rt_i = rt; {rd_i, shamt_i, funct_i} = imm;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rtype(32'd2, 32'd3, 5'd4, 5'd0, 6'h20);
    tick;
    n_cmp++; if (ma_c_o !== 32'd0) begin n_err++; $display("FAIL reset_c got %h exp %h", ma_c_o, 32'd0); end
    n_cmp++; if (ma_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_addr got %h exp %h", ma_addr_o, 5'd0); end
    n_cmp++; if (ma_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp %b", ma_we_o, 1'b0); end
    n_cmp++; if (c_o !== 32'd5) begin n_err++; $display("FAIL reset_comb_c got %h exp %h", c_o, 32'd5); end
    RSTn = 1'b1;
  endtask

  task automatic test_add;
    rtype(32'h7FFFFFFF, 32'h1, 5'd5, 5'd0, 6'h20);
    n_cmp++; if (c_o !== 32'h80000000) begin n_err++; $display("FAIL add_c got %h exp %h", c_o, 32'h80000000); end
    n_cmp++; if (alu_ctrl_o !== 4'h0) begin n_err++; $display("FAIL add_ctrl got %h exp %h", alu_ctrl_o, 4'h0); end
    n_cmp++; if (z_o !== 1'b0) begin n_err++; $display("FAIL add_z got %b exp %b", z_o, 1'b0); end
    tick;
    n_cmp++; if (ma_c_o !== 32'h80000000) begin n_err++; $display("FAIL add_ma_c got %h exp %h", ma_c_o, 32'h80000000); end
    n_cmp++; if (ma_addr_o !== 5'd5) begin n_err++; $display("FAIL add_ma_addr got %h exp %h", ma_addr_o, 5'd5); end
    n_cmp++; if (ma_we_o !== 1'b1) begin n_err++; $display("FAIL add_ma_we got %b exp %b", ma_we_o, 1'b1); end
    rtype(32'hFFFFFFFF, 32'h2, 5'd6, 5'd0, 6'h21);
    n_cmp++; if (c_o !== 32'h1) begin n_err++; $display("FAIL addu_wrap got %h exp %h", c_o, 32'h1); end
  endtask

  task automatic test_sub_cmp;
    rtype(32'h12345678, 32'h12345678, 5'd3, 5'd0, 6'h22);
    n_cmp++; if (c_o !== 32'h0) begin n_err++; $display("FAIL sub_c got %h exp %h", c_o, 32'h0); end
    n_cmp++; if (z_o !== 1'b1) begin n_err++; $display("FAIL sub_z got %b exp %b", z_o, 1'b1); end
    n_cmp++; if (alu_ctrl_o !== 4'h1) begin n_err++; $display("FAIL sub_ctrl got %h exp %h", alu_ctrl_o, 4'h1); end
    rtype(32'h0, 32'h1, 5'd3, 5'd0, 6'h23);
    n_cmp++; if (c_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL subu_wrap got %h exp %h", c_o, 32'hFFFFFFFF); end
    rtype(32'hFFFFFFFF, 32'h1, 5'd3, 5'd0, 6'h2A);
    n_cmp++; if (c_o !== 32'd1) begin n_err++; $display("FAIL slt got %h exp %h", c_o, 32'd1); end
    rtype(32'hFFFFFFFF, 32'h1, 5'd3, 5'd0, 6'h2B);
    n_cmp++; if (c_o !== 32'd0) begin n_err++; $display("FAIL sltu got %h exp %h", c_o, 32'd0); end
    n_cmp++; if (alu_ctrl_o !== 4'h7) begin n_err++; $display("FAIL sltu_ctrl got %h exp %h", alu_ctrl_o, 4'h7); end
  endtask

  task automatic test_logic;
    rtype(32'h0000F0F0, 32'h0000FF00, 5'd8, 5'd0, 6'h24);
    n_cmp++; if (c_o !== 32'h0000F000) begin n_err++; $display("FAIL and got %h exp %h", c_o, 32'h0000F000); end
    rtype(32'h0000F0F0, 32'h0000FF00, 5'd8, 5'd0, 6'h25);
    n_cmp++; if (c_o !== 32'h0000FFF0) begin n_err++; $display("FAIL or got %h exp %h", c_o, 32'h0000FFF0); end
    rtype(32'h0000F0F0, 32'h0000FF00, 5'd8, 5'd0, 6'h26);
    n_cmp++; if (c_o !== 32'h00000FF0) begin n_err++; $display("FAIL xor got %h exp %h", c_o, 32'h00000FF0); end
    rtype(32'h0000F0F0, 32'h0000FF00, 5'd8, 5'd0, 6'h27);
    n_cmp++; if (c_o !== 32'hFFFF000F) begin n_err++; $display("FAIL nor got %h exp %h", c_o, 32'hFFFF000F); end
  endtask

  task automatic test_immediates;
    itype(6'h08, 32'd5, 5'd7, 16'hFFFF);
    n_cmp++; if (c_o !== 32'd4) begin n_err++; $display("FAIL addi got %h exp %h", c_o, 32'd4); end
    tick;
    n_cmp++; if (ma_addr_o !== 5'd7) begin n_err++; $display("FAIL addi_dest got %h exp %h", ma_addr_o, 5'd7); end
    n_cmp++; if (ma_we_o !== 1'b1) begin n_err++; $display("FAIL addi_we got %b exp %b", ma_we_o, 1'b1); end
    itype(6'h0D, 32'd0, 5'd7, 16'hFFFF);
    n_cmp++; if (c_o !== 32'h0000FFFF) begin n_err++; $display("FAIL ori got %h exp %h", c_o, 32'h0000FFFF); end
    itype(6'h0C, 32'hFFFFFFFF, 5'd7, 16'h8001);
    n_cmp++; if (c_o !== 32'h00008001) begin n_err++; $display("FAIL andi got %h exp %h", c_o, 32'h00008001); end
    itype(6'h0E, 32'hFFFF0000, 5'd7, 16'h8000);
    n_cmp++; if (c_o !== 32'hFFFF8000) begin n_err++; $display("FAIL xori got %h exp %h", c_o, 32'hFFFF8000); end
    itype(6'h0F, 32'hDEADBEEF, 5'd12, 16'h1234);
    n_cmp++; if (c_o !== 32'h12340000) begin n_err++; $display("FAIL lui got %h exp %h", c_o, 32'h12340000); end
    n_cmp++; if (alu_ctrl_o !== 4'hB) begin n_err++; $display("FAIL lui_ctrl got %h exp %h", alu_ctrl_o, 4'hB); end
    tick;
    n_cmp++; if (ma_c_o !== 32'h12340000) begin n_err++; $display("FAIL lui_ma_c got %h exp %h", ma_c_o, 32'h12340000); end
    n_cmp++; if (ma_addr_o !== 5'd12) begin n_err++; $display("FAIL lui_dest got %h exp %h", ma_addr_o, 5'd12); end
    itype(6'h0A, 32'hFFFFFFFE, 5'd7, 16'hFFFF);
    n_cmp++; if (c_o !== 32'd1) begin n_err++; $display("FAIL slti got %h exp %h", c_o, 32'd1); end
    itype(6'h0B, 32'd5, 5'd7, 16'hFFFF);
    n_cmp++; if (c_o !== 32'd1) begin n_err++; $display("FAIL sltiu got %h exp %h", c_o, 32'd1); end
  endtask

  task automatic test_shifts;
    rtype(32'h0, 32'h80000000, 5'd2, 5'd4, 6'h03);
    n_cmp++; if (c_o !== 32'hF8000000) begin n_err++; $display("FAIL sra got %h exp %h", c_o, 32'hF8000000); end
    rtype(32'h24, 32'hF0, 5'd2, 5'd0, 6'h06);
    n_cmp++; if (c_o !== 32'h0F) begin n_err++; $display("FAIL srlv got %h exp %h", c_o, 32'h0F); end
    rtype(32'h0, 32'hDEADBEEF, 5'd2, 5'd0, 6'h00);
    n_cmp++; if (c_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL sll0 got %h exp %h", c_o, 32'hDEADBEEF); end
    rtype(32'h0, 32'h80000000, 5'd2, 5'd31, 6'h02);
    n_cmp++; if (c_o !== 32'h1) begin n_err++; $display("FAIL srl31 got %h exp %h", c_o, 32'h1); end
    rtype(32'h21, 32'h1, 5'd2, 5'd7, 6'h04);
    n_cmp++; if (c_o !== 32'h2) begin n_err++; $display("FAIL sllv got %h exp %h", c_o, 32'h2); end
    rtype(32'h3, 32'h80000010, 5'd2, 5'd0, 6'h07);
    n_cmp++; if (c_o !== 32'hF0000002) begin n_err++; $display("FAIL srav got %h exp %h", c_o, 32'hF0000002); end
  endtask

  task automatic test_illegal;
    itype(6'h3F, 32'h11111111, 5'd7, 16'h1234);
    n_cmp++; if (alu_ctrl_o !== 4'hF) begin n_err++; $display("FAIL illegal_ctrl got %h exp %h", alu_ctrl_o, 4'hF); end
    n_cmp++; if (c_o !== 32'h0) begin n_err++; $display("FAIL illegal_c got %h exp %h", c_o, 32'h0); end
    tick;
    n_cmp++; if (ma_we_o !== 1'b0) begin n_err++; $display("FAIL illegal_we got %b exp %b", ma_we_o, 1'b0); end
    rtype(32'h5, 32'h6, 5'd9, 5'd0, 6'h01);
    n_cmp++; if (alu_ctrl_o !== 4'hF) begin n_err++; $display("FAIL bad_funct_ctrl got %h exp %h", alu_ctrl_o, 4'hF); end
    rtype(32'h5, 32'h6, 5'd0, 5'd0, 6'h20);
    n_cmp++; if (c_o !== 32'd11) begin n_err++; $display("FAIL add_r0_c got %h exp %h", c_o, 32'd11); end
    tick;
    n_cmp++; if (ma_we_o !== 1'b0) begin n_err++; $display("FAIL add_r0_we got %b exp %b", ma_we_o, 1'b0); end
    n_cmp++; if (ma_c_o !== 32'd11) begin n_err++; $display("FAIL add_r0_ma_c got %h exp %h", ma_c_o, 32'd11); end
  endtask

  task automatic test_back_to_back;
    rtype(32'd10, 32'd20, 5'd1, 5'd0, 6'h20);
    tick;
    n_cmp++; if (ma_c_o !== 32'd30) begin n_err++; $display("FAIL b2b1_c got %h exp %h", ma_c_o, 32'd30); end
    itype(6'h09, 32'd100, 5'd2, 16'd1);
    tick;
    n_cmp++; if (ma_c_o !== 32'd101) begin n_err++; $display("FAIL b2b2_c got %h exp %h", ma_c_o, 32'd101); end
    n_cmp++; if (ma_addr_o !== 5'd2) begin n_err++; $display("FAIL b2b2_addr got %h exp %h", ma_addr_o, 5'd2); end
    rtype(32'd1, 32'd2, 5'd17, 5'd0, 6'h20);
    RSTn = 1'b0;
    tick;
    n_cmp++; if (ma_c_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_c got %h exp %h", ma_c_o, 32'd0); end
    n_cmp++; if (ma_addr_o !== 5'd0) begin n_err++; $display("FAIL rst_mid_addr got %h exp %h", ma_addr_o, 5'd0); end
    n_cmp++; if (ma_we_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_we got %b exp %b", ma_we_o, 1'b0); end
    @(negedge CLK);
    RSTn = 1'b1;
    tick;
    n_cmp++; if (ma_c_o !== 32'd3) begin n_err++; $display("FAIL rst_rel_c got %h exp %h", ma_c_o, 32'd3); end
    n_cmp++; if (ma_addr_o !== 5'd17) begin n_err++; $display("FAIL rst_rel_addr got %h exp %h", ma_addr_o, 5'd17); end
    n_cmp++; if (ma_we_o !== 1'b1) begin n_err++; $display("FAIL rst_rel_we got %b exp %b", ma_we_o, 1'b1); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_cmp;
    test_logic;
    test_immediates;
    test_shifts;
    test_illegal;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
